// File: rtl/seq_divider_if.sv
// Handshake and data bundle for the sequential divider.
// The divider takes the slave modport and the requester takes the master modport.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic             ovf;

  modport master (
    output start, signed_op, dividend, divisor,
    input  quot, rem, busy, done, div_zero, ovf
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output quot, rem, busy, done, div_zero, ovf
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider with unsigned and two's-complement modes.
// It works on magnitudes and applies the signs in a single fix-up cycle.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  seq_divider_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_next_s;

  logic [WIDTH-1:0] q_acc_r;
  logic [WIDTH-1:0] r_acc_r;
  logic [WIDTH-1:0] dvs_mag_r;
  logic [CW-1:0]    count_r;
  logic             sq_r;
  logic             sr_r;
  logic             ovf_pend_r;

  logic [WIDTH-1:0] quot_r;
  logic [WIDTH-1:0] rem_r;
  logic             busy_r;
  logic             done_r;
  logic             div_zero_r;
  logic             ovf_r;

  logic             div0_s;
  logic [WIDTH:0]   r_shift_s;
  logic [WIDTH:0]   trial_s;

  // The most negative value maps to 2^(WIDTH-1), which still fits unsigned.
  function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] v, input logic sgn_en);
    logic [WIDTH-1:0] m;
    if (sgn_en && v[WIDTH-1]) begin
      m = -v;
    end else begin
      m = v;
    end
    return m;
  endfunction

  // Next-state decode and one restoring-step trial subtraction.
  always_comb begin
    state_next_s = state_r;
    div0_s       = (bus.divisor == {WIDTH{1'b0}});
    r_shift_s    = {r_acc_r, q_acc_r[WIDTH-1]};
    trial_s      = r_shift_s - {1'b0, dvs_mag_r};
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          if (div0_s) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_CALC;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (count_r == CW'(WIDTH - 1)) begin
          state_next_s = ST_FIX;
        end else begin
          state_next_s = ST_CALC;
        end
      end
      ST_FIX:  state_next_s = ST_DONE;
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register plus busy/done strobes registered from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == ST_CALC) || (state_next_s == ST_FIX);
      done_r  <= (state_next_s == ST_DONE);
    end
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_acc_r    <= {WIDTH{1'b0}};
      r_acc_r    <= {WIDTH{1'b0}};
      dvs_mag_r  <= {WIDTH{1'b0}};
      count_r    <= {CW{1'b0}};
      sq_r       <= 1'b0;
      sr_r       <= 1'b0;
      ovf_pend_r <= 1'b0;
      quot_r     <= {WIDTH{1'b0}};
      rem_r      <= {WIDTH{1'b0}};
      div_zero_r <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            if (div0_s) begin
              quot_r     <= {WIDTH{1'b1}};
              rem_r      <= bus.dividend;
              div_zero_r <= 1'b1;
              ovf_r      <= 1'b0;
            end else begin
              q_acc_r    <= mag_f(bus.dividend, bus.signed_op);
              dvs_mag_r  <= mag_f(bus.divisor, bus.signed_op);
              r_acc_r    <= {WIDTH{1'b0}};
              count_r    <= {CW{1'b0}};
              sq_r       <= bus.signed_op & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
              sr_r       <= bus.signed_op & bus.dividend[WIDTH-1];
              ovf_pend_r <= bus.signed_op
                            && (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}})
                            && (bus.divisor == {WIDTH{1'b1}});
            end
          end
        end
        ST_CALC: begin
          // Remainder after a successful trial is below the divisor, so WIDTH bits suffice.
          if (!trial_s[WIDTH]) begin
            r_acc_r <= trial_s[WIDTH-1:0];
            q_acc_r <= {q_acc_r[WIDTH-2:0], 1'b1};
          end else begin
            r_acc_r <= r_shift_s[WIDTH-1:0];
            q_acc_r <= {q_acc_r[WIDTH-2:0], 1'b0};
          end
          count_r <= count_r + CW'(1);
        end
        ST_FIX: begin
          quot_r     <= sq_r ? -q_acc_r : q_acc_r;
          rem_r      <= sr_r ? -r_acc_r : r_acc_r;
          div_zero_r <= 1'b0;
          ovf_r      <= ovf_pend_r;
        end
        ST_DONE: begin
          quot_r <= quot_r;
        end
        default: begin
          quot_r <= quot_r;
        end
      endcase
    end
  end

  assign bus.quot     = quot_r;
  assign bus.rem      = rem_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.div_zero = div_zero_r;
  assign bus.ovf      = ovf_r;

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider (WIDTH=8) with hand-computed results.
module tb_seq_divider;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  seq_divider_if #(.WIDTH(8)) bus ();

  seq_divider #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Launch one division; elat is the number of edges after the start edge before done is seen.
  task automatic do_div(input string tag, input logic s, input logic [7:0] dd, input logic [7:0] dv,
                        input logic [7:0] eq, input logic [7:0] er, input logic edz,
                        input logic eov, input int elat, input bit poke);
    int k;
    int busy_cnt;
    bit seen;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.signed_op = s;
    bus.dividend  = dd;
    bus.divisor   = dv;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.signed_op = ~s;
    bus.dividend  = 8'h5A;
    bus.divisor   = 8'h0C;
    k = 0;
    busy_cnt = 0;
    seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (bus.busy) busy_cnt++;
        k++;
      end
      if (poke && k == 3) begin
        bus.start    = 1'b1;
        bus.dividend = 8'h10;
        bus.divisor  = 8'h03;
      end else begin
        bus.start = 1'b0;
      end
    end
    chk({tag, "_done"}, 32'(seen), 32'd1);
    chk({tag, "_lat"}, k, elat);
    chk({tag, "_busy"}, busy_cnt, elat);
    chk({tag, "_quot"}, 32'(bus.quot), 32'(eq));
    chk({tag, "_rem"}, 32'(bus.rem), 32'(er));
    chk({tag, "_dz"}, 32'(bus.div_zero), 32'(edz));
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'(eov));
    @(negedge clk);
    chk({tag, "_done1cyc"}, 32'(bus.done), 32'd0);
    chk({tag, "_quot_hold"}, 32'(bus.quot), 32'(eq));
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.dividend  = 8'h00;
    bus.divisor   = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_quot", 32'(bus.quot), 32'd0);
    chk("rst_rem", 32'(bus.rem), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_flags", 32'({bus.div_zero, bus.ovf}), 32'd0);
    reset = 1'b1;

    do_div("u100_7",   1'b0, 8'd100, 8'd7,  8'd14,  8'd2,  1'b0, 1'b0, 9, 1'b0);
    do_div("s_m7_2",   1'b1, 8'hF9,  8'h02, 8'hFD,  8'hFF, 1'b0, 1'b0, 9, 1'b0);
    do_div("s_7_m2",   1'b1, 8'h07,  8'hFE, 8'hFD,  8'h01, 1'b0, 1'b0, 9, 1'b0);
    do_div("s_m100_7", 1'b1, 8'h9C,  8'h07, 8'hF2,  8'hFE, 1'b0, 1'b0, 9, 1'b0);
    do_div("dz",       1'b0, 8'h37,  8'h00, 8'hFF,  8'h37, 1'b1, 1'b0, 0, 1'b0);
    do_div("u9_3",     1'b0, 8'd9,   8'd3,  8'd3,   8'd0,  1'b0, 1'b0, 9, 1'b0);
    do_div("s_ovf",    1'b1, 8'h80,  8'hFF, 8'h80,  8'h00, 1'b0, 1'b1, 9, 1'b0);
    do_div("u80_ff",   1'b0, 8'h80,  8'hFF, 8'h00,  8'h80, 1'b0, 1'b0, 9, 1'b0);
    do_div("u_ff_1",   1'b0, 8'hFF,  8'h01, 8'hFF,  8'h00, 1'b0, 1'b0, 9, 1'b1);

    // Abort mid-calculation: outputs must clear without waiting for a clock edge.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.signed_op = 1'b0;
    bus.dividend  = 8'd100;
    bus.divisor   = 8'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_quot", 32'(bus.quot), 32'd0);
    chk("arst_rem", 32'(bus.rem), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_flags", 32'({bus.done, bus.div_zero, bus.ovf}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("arst_nodone", 32'(bus.done), 32'd0);
    end
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("post_rst_nodone", 32'(bus.done), 32'd0);
    end
    do_div("u50_5", 1'b0, 8'd50, 8'd5, 8'd10, 8'd0, 1'b0, 1'b0, 9, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
